// File: rtl/timeslot_capture.sv
// Capture FIFO for a time-multiplexed sample stream. It stores {slot, data} pairs,
// keeps a saturating count of accepted samples per slot and a sticky overflow flag.
module timeslot_capture #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_slot,
  input  logic                       in_en,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_slot,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                count0,
  output logic [15:0]                count1,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;

  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_en && ((level != FULL) || pop);

  assign out_slot  = mem[rd_ptr][WIDTH];
  assign out_data  = mem[rd_ptr][WIDTH-1:0];

  // NOTE: storage is not reset; out_valid qualifies the head, so stale
  // contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {in_slot, in_data};
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      count0   <= '0;
      count1   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (in_en && !push) begin
        overflow <= 1'b1;
      end
      if (push && !in_slot && (count0 != CNT_MAX)) begin
        count0 <= count0 + 1'b1;
      end
      if (push && in_slot && (count1 != CNT_MAX)) begin
        count1 <= count1 + 1'b1;
      end
    end
  end

endmodule

// File: doc/timeslot_capture.md
TIMESLOT_CAPTURE -- requirements
Module: timeslot_capture

Interface
REQ-001 The module SHALL take parameter WIDTH, default 16: width of a captured sample.
REQ-002 The module SHALL take parameter DEPTH, default 4: FIFO entries; must be a power of 2, minimum 2.
REQ-003 The module SHALL have port clk  input  1  {L}  single clock; all state updates on posedge clk.
REQ-004 The module SHALL have port rst  input  1  {L}  reset, synchronous, active-high.
REQ-005 The module SHALL have port in_data  input  WIDTH  {L}  sample from the upstream time-multiplexed output register.
REQ-006 The module SHALL have port in_slot  input  1  {L}  slot tag for in_data, equal to the upstream timer LSB.
REQ-007 The module SHALL have port in_en  input  1  {L}  capture request; in_data/in_slot are sampled when it is high.
REQ-008 The module SHALL have port out_data  output  WIDTH  {L}  head-of-FIFO sample.
REQ-009 The module SHALL have port out_slot  output  1  {L}  slot tag of the head sample.
REQ-010 The module SHALL have port out_valid  output  1  {L}  head entry is valid.
REQ-011 The module SHALL have port out_ready  input  1  {L}  consumer accepts the head entry.
REQ-012 The module SHALL have port count0  output  16  {L}  accepted samples with slot 0.
REQ-013 The module SHALL have port count1  output  16  {L}  accepted samples with slot 1.
REQ-014 The module SHALL have port level  output  log2(DEPTH)+1  {L}  current FIFO occupancy, 0..DEPTH.
REQ-015 The module SHALL have port overflow  output  1  {L}  sticky flag for a dropped sample.
REQ-016 Every port and internal register SHALL carry label {L}; the block SHALL type-check with no {H} or dependent labels.

Function
REQ-017 The FIFO SHALL store {in_slot, in_data} pairs in arrival order with DEPTH entries; read and write pointers SHALL wrap modulo DEPTH.
REQ-018 Push SHALL occur when in_en=1 and either level<DEPTH or pop occurs in the same cycle.
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1; the head SHALL advance on the next edge.
REQ-020 out_valid SHALL equal (level!=0); out_data/out_slot SHALL present the head entry combinationally from the storage array, and SHALL be don't-care when out_valid=0.
REQ-021 Latency: a sample pushed into an empty FIFO at edge N SHALL appear with out_valid=1 in the cycle following edge N.
REQ-022 level SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-023 Simultaneous push and pop with level=DEPTH SHALL accept the new sample; level stays DEPTH and overflow is not set.
REQ-024 With level=0 and in_en=1, pop SHALL NOT occur in that cycle, because out_valid=0; the FIFO SHALL have no bypass.
REQ-025 When in_en=1 and push is refused, the sample SHALL be dropped and overflow SHALL be set to 1.
REQ-026 overflow SHALL remain 1 until rst.
REQ-027 On each accepted push, count0 or count1 SHALL increment according to in_slot.
REQ-028 count0 and count1 SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 Dropped samples SHALL NOT be counted.
REQ-030 Output behaviour SHALL depend only on {L} inputs and {L} state; no output may be timing-modulated by data values.

Reset
REQ-031 When rst=1 at a posedge, the module SHALL set: pointers=0, level=0, out_valid=0, count0=0, count1=0, overflow=0.
REQ-032 Storage array contents need not be reset.
REQ-033 rst SHALL override any simultaneous push or pop in that cycle; in-flight FIFO contents SHALL be discarded.
REQ-034 After reset deasserts, the first push SHALL be accepted on the next edge.

Verification
REQ-035 The bench SHALL cover basic flow: after reset, in_en=1 for 1 cycle with in_data=16'h0064, in_slot=1, out_ready=0 -> next cycle out_valid=1, out_data=16'h0064, out_slot=1, level=1, count1=1.
REQ-036 The bench SHALL cover fill/overflow: 5 pushes (16'h0001..16'h0005), out_ready=0, DEPTH=4 -> level=4, overflow=1, count0+count1=4; draining then yields 1,2,3,4 only.
REQ-037 The bench SHALL cover full with simultaneous push/pop: level=4, in_en=1, out_ready=1 -> level stays 4, overflow stays 0, new sample emerges 4 pops later.
REQ-038 The bench SHALL cover wrap-around: 10 alternating push/pop cycles with slot toggling 0,1,... -> output order matches input order, count0=5, count1=5, level returns to 0.
REQ-039 The bench SHALL cover reset mid-operation: level=3, overflow=1, rst=1 for 1 cycle with in_en=1 -> next cycle level=0, out_valid=0, overflow=0, counts=0.
REQ-040 The bench SHALL cover saturation: count0 forced/preloaded near 16'hFFFE, 3 slot-0 pushes -> count0=16'hFFFF, count1 unchanged.
